// File: rtl/dl11_console_pkg.sv
// Shared definitions for the DL11 console block: register offsets, CSR bit
// positions, state encodings and register-word builders.
package dl11_console_pkg;

    localparam logic [1:0] ADDR_RCSR = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_XCSR = 2'd2;
    localparam logic [1:0] ADDR_XBUF = 2'd3;

    localparam int CSR_DONE_BIT = 7;
    localparam int CSR_IE_BIT   = 6;
    localparam int RBUF_OVR_BIT = 14;
    localparam int RBUF_ERR_BIT = 15;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_BUSY = 2'd2
    } tx_fsm_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    // Status word shared by RCSR and XCSR: flag in bit 7, interrupt enable in bit 6.
    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        logic [15:0] w;
        w = 16'h0000;
        w[CSR_DONE_BIT] = flag;
        w[CSR_IE_BIT]   = ie;
        return w;
    endfunction

    // Receive buffer word: data byte plus the overrun flag mirrored into ERR.
    function automatic logic [15:0] rbuf_word(input logic ovr, input logic [7:0] data);
        logic [15:0] w;
        w = {8'h00, data};
        w[RBUF_OVR_BIT] = ovr;
        w[RBUF_ERR_BIT] = ovr;
        return w;
    endfunction

endpackage

// File: rtl/dl11_console_if.sv
// CPU-side register bus of the DL11 console.
interface dl11_console_if;
    logic        bus_sel;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    modport master (
        output bus_sel, bus_rd, bus_wr, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_sel, bus_rd, bus_wr, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/dl11_console_fifo.sv
// Synchronous byte FIFO buffering received characters until the CPU reads them.
// A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Accept/reject decisions and next pointer/count values.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/dl11_console_uart.sv
// 8N1 serial receiver and transmitter used by the DL11 console.

// Receiver: two-flop synchroniser, mid-bit sampling, ready flag held until cleared.
module uart_rx
    import dl11_console_pkg::*;
#(
    parameter int CLK_FRQ   = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd_i,
    input  logic       rx_clear_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_ready_o
);
    localparam int CPB = CLK_FRQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          rxd_meta_q, rxd_sync_q;

    assign rx_data_o       = data_q;
    assign rx_data_ready_o = ready_q;

    // Frame sequencing: confirm start at mid-bit, shift data LSB first, check stop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = rx_clear_i ? 1'b0 : ready_q;
        case (state_q)
            U_IDLE: begin
                cnt_d   = {CW{1'b0}};
                state_d = rxd_sync_q ? U_IDLE : U_START;
            end
            U_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = {CW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = rxd_sync_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = U_IDLE;
                    if (rxd_sync_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        data_d = data_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    // Receiver state registers and input synchroniser (line idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= U_IDLE;
            cnt_q      <= {CW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
        end
    end
endmodule

// Transmitter: latches the byte on tx_send while idle; tx_ready low for the whole frame.
module uart_tx
    import dl11_console_pkg::*;
#(
    parameter int CLK_FRQ   = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_send_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       txd_o
);
    localparam int CPB = CLK_FRQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    assign tx_ready_o = (state_q == U_IDLE);
    assign txd_o      = txd_q;

    // Frame sequencing: start bit, eight data bits LSB first, stop bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            U_IDLE: begin
                cnt_d = {CW{1'b0}};
                bit_d = 3'd0;
                if (tx_send_i) begin
                    state_d = U_START;
                    shift_d = tx_data_i;
                    txd_d   = 1'b0;
                end else begin
                    state_d = U_IDLE;
                    txd_d   = 1'b1;
                end
            end
            U_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = U_DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = U_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = U_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; the serial line resets to the idle (mark) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= U_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: rtl/dl11_console.sv
// DL11-style console: RCSR/RBUF/XCSR/XBUF register responder in front of a
// buffered UART receiver and a UART transmitter, with level interrupt requests.
module dl11_console
    import dl11_console_pkg::*;
#(
    parameter int CLK_FRQ       = 27_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    dl11_console_if.slave  bus,
    output logic           rx_irq,
    output logic           tx_irq,
    input  logic           uart_rxd,
    output logic           uart_txd
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    tx_fsm_t     tx_state_q, tx_state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  xbuf_q, xbuf_d;
    logic [7:0]  last_q, last_d;
    logic        rie_q, rie_d, tie_q, tie_d;
    logic        ovr_q, ovr_d;
    logic        rx_clr_q, rx_clr_d;
    logic        rx_irq_q, rx_irq_d, tx_irq_q, tx_irq_d;

    logic        rd_s, wr_s, rbuf_rd_s, done_s, ready_s, overrun_s;
    logic        fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [7:0]  fifo_head_s, rx_data_s;
    logic [AW:0] fifo_count_s;
    logic        rx_data_ready_s, tx_send_s, tx_ready_s;

    assign bus.bus_rdata = rdata_q;
    assign rx_irq        = rx_irq_q;
    assign tx_irq        = tx_irq_q;

    uart_rx #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk             (clk),
        .reset_n         (reset_n),
        .rxd_i           (uart_rxd),
        .rx_clear_i      (rx_clr_q),
        .rx_data_o       (rx_data_s),
        .rx_data_ready_o (rx_data_ready_s)
    );

    uart_tx #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_send_i  (tx_send_s),
        .tx_data_i  (xbuf_q),
        .tx_ready_o (tx_ready_s),
        .txd_o      (uart_txd)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .din_i   (rx_data_s),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Register decode, RX FIFO control, overrun tracking and interrupt levels.
    always_comb begin
        rd_s      = bus.bus_sel & bus.bus_rd;
        wr_s      = bus.bus_sel & bus.bus_wr;
        rbuf_rd_s = rd_s & (bus.bus_addr == ADDR_RBUF);
        done_s    = (fifo_count_s != {(AW+1){1'b0}});
        ready_s   = (tx_state_q == T_IDLE);

        // rx_clr_q masks the flag for the cycle it takes uart_rx to drop it.
        fifo_push_s = rx_data_ready_s & ~rx_clr_q;
        rx_clr_d    = fifo_push_s;
        fifo_pop_s  = rbuf_rd_s & ~fifo_empty_s;
        overrun_s   = fifo_push_s & fifo_full_s & ~fifo_pop_s;
        ovr_d       = overrun_s | (ovr_q & ~rbuf_rd_s);
        last_d      = fifo_pop_s ? fifo_head_s : last_q;

        rie_d = (wr_s && bus.bus_addr == ADDR_RCSR) ? bus.bus_wdata[CSR_IE_BIT] : rie_q;
        tie_d = (wr_s && bus.bus_addr == ADDR_XCSR) ? bus.bus_wdata[CSR_IE_BIT] : tie_q;

        rx_irq_d = rie_q & done_s;
        tx_irq_d = tie_q & ready_s;

        rdata_d = rdata_q;
        if (rd_s) begin
            case (bus.bus_addr)
                ADDR_RCSR: rdata_d = csr_word(done_s, rie_q);
                ADDR_RBUF: rdata_d = rbuf_word(ovr_q, fifo_empty_s ? last_q : fifo_head_s);
                ADDR_XCSR: rdata_d = csr_word(ready_s, tie_q);
                ADDR_XBUF: rdata_d = 16'h0000;
                default:   rdata_d = 16'h0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Transmit handshake FSM: request until uart_tx goes busy, then wait for idle.
    always_comb begin
        tx_state_d = tx_state_q;
        xbuf_d     = xbuf_q;
        tx_send_s  = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (wr_s && bus.bus_addr == ADDR_XBUF) begin
                    xbuf_d     = bus.bus_wdata[7:0];
                    tx_state_d = T_REQ;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_REQ: begin
                tx_send_s  = 1'b1;
                tx_state_d = tx_ready_s ? T_REQ : T_BUSY;
            end
            T_BUSY: begin
                tx_state_d = tx_ready_s ? T_IDLE : T_BUSY;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Console state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= T_IDLE;
            rdata_q    <= 16'h0000;
            xbuf_q     <= 8'h00;
            last_q     <= 8'h00;
            rie_q      <= 1'b0;
            tie_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rx_clr_q   <= 1'b0;
            rx_irq_q   <= 1'b0;
            tx_irq_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rdata_q    <= rdata_d;
            xbuf_q     <= xbuf_d;
            last_q     <= last_d;
            rie_q      <= rie_d;
            tie_q      <= tie_d;
            ovr_q      <= ovr_d;
            rx_clr_q   <= rx_clr_d;
            rx_irq_q   <= rx_irq_d;
            tx_irq_q   <= tx_irq_d;
        end
    end
endmodule
